// File: rtl/vec_seq_pkg.sv
// Shared opcodes, state/primitive encodings, argument-count table and clip limits
// for the vector sequencer.
package vec_seq_pkg;

   localparam logic [7:0] OP_SET_PAL   = 8'h10;
   localparam logic [7:0] OP_MOVE      = 8'h11;
   localparam logic [7:0] OP_LINE      = 8'h13;
   localparam logic [7:0] OP_QUAD      = 8'h14;
   localparam logic [7:0] OP_CUBIC     = 8'h15;
   localparam logic [7:0] OP_SET_COLOR = 8'h18;
   localparam logic [7:0] OP_SHOW      = 8'h19;

   localparam logic [15:0] X_MAX = 16'd639;
   localparam logic [15:0] Y_MAX = 16'd399;

   localparam int MAX_ARGS = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_OP,
      ST_FETCH_ARG,
      ST_ISSUE,
      ST_WAIT_DRAW,
      ST_DONE,
      ST_ERROR
   } state_e;

   typedef enum logic [1:0] {
      PT_LINE  = 2'd0,
      PT_QUAD  = 2'd1,
      PT_CUBIC = 2'd2
   } prim_type_e;

   // Argument bytes following each opcode; zero for SHOW and for undefined codes.
   function automatic logic [3:0] arg_count(input logic [7:0] op);
      case (op)
         OP_SET_PAL, OP_MOVE, OP_LINE: arg_count = 4'd4;
         OP_QUAD:                      arg_count = 4'd8;
         OP_CUBIC:                     arg_count = 4'd12;
         OP_SET_COLOR:                 arg_count = 4'd1;
         default:                      arg_count = 4'd0;
      endcase
   endfunction

   function automatic logic op_valid(input logic [7:0] op);
      case (op)
         OP_SET_PAL, OP_MOVE, OP_LINE, OP_QUAD,
         OP_CUBIC, OP_SET_COLOR, OP_SHOW: op_valid = 1'b1;
         default:                         op_valid = 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lim);
      clamp16 = (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/vector_sequencer_arg_fetch.sv
// vec_arg_fetch: collects argument bytes by position and splits them into points,
// palette index and YCC triple. Coordinates are clamped when VEC_SEQ_CLIP_EN is defined.
module vec_arg_fetch
   import vec_seq_pkg::*;
#(
   parameter int X_W    = 10,
   parameter int Y_W    = 9,
   parameter int PAL_AW = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                byte_valid,
   input  logic [7:0]          byte_data,
   output logic [3:0]          rcv_cnt,
   output logic [3*X_W-1:0]    pt_x,
   output logic [3*Y_W-1:0]    pt_y,
   output logic [PAL_AW-1:0]   idx,
   output logic [23:0]         ycc
);

   logic [3:0] rcv_cnt_reg;
   logic [7:0] byte_reg [MAX_ARGS];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rcv_cnt_reg <= 4'd0;
         for (int i = 0; i < MAX_ARGS; i++) byte_reg[i] <= 8'h00;
      end else if (clear) begin
         rcv_cnt_reg <= 4'd0;
      end else if (byte_valid && (rcv_cnt_reg < 4'(MAX_ARGS))) begin
         byte_reg[rcv_cnt_reg] <= byte_data;
         rcv_cnt_reg           <= rcv_cnt_reg + 4'd1;
      end
   end

   assign rcv_cnt = rcv_cnt_reg;
   assign idx     = PAL_AW'(byte_reg[0]);
   assign ycc     = {byte_reg[1], byte_reg[2], byte_reg[3]};

   // Point gi occupies bytes 4gi..4gi+3 as big-endian x then y.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_point
         logic [15:0] raw_x, raw_y, cx, cy;
         assign raw_x = {byte_reg[4*gi],   byte_reg[4*gi+1]};
         assign raw_y = {byte_reg[4*gi+2], byte_reg[4*gi+3]};
`ifdef VEC_SEQ_CLIP_EN
         assign cx = clamp16(raw_x, X_MAX);
         assign cy = clamp16(raw_y, Y_MAX);
`else
         assign cx = raw_x;
         assign cy = raw_y;
`endif
         assign pt_x[gi*X_W +: X_W] = X_W'(cx);
         assign pt_y[gi*Y_W +: Y_W] = Y_W'(cy);
      end
   endgenerate

endmodule

// File: rtl/vector_sequencer.sv
// Byte-code vector sequencer: fetches opcodes/arguments from program memory and issues
// line/quad/cubic primitives and palette writes. Optional clamp: VEC_SEQ_CLIP_EN.
module vector_sequencer
   import vec_seq_pkg::*;
#(
   parameter int X_W     = 10,
   parameter int Y_W     = 9,
   parameter int PROG_AW = 10,
   parameter int PAL_AW  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [PROG_AW-1:0]  prog_addr,
   output logic                prog_rd,
   input  logic [7:0]          prog_data,
   output logic                prim_valid,
   input  logic                prim_ready,
   output logic [1:0]          prim_type,
   output logic [4*X_W-1:0]    prim_x,
   output logic [4*Y_W-1:0]    prim_y,
   output logic [PAL_AW-1:0]   color_o,
   input  logic                draw_done,
   output logic                pal_we,
   output logic [PAL_AW-1:0]   pal_idx,
   output logic [23:0]         pal_ycc
);

   localparam logic [PROG_AW-1:0] PC_LAST = '1;

   state_e              state_reg, state_next;
   logic [PROG_AW-1:0]  pc_reg;
   logic [7:0]          op_reg;
   logic [3:0]          arg_cnt_reg, iss_cnt_reg;
   logic                rd_valid_reg;
   logic [X_W-1:0]      cur_x_reg;
   logic [Y_W-1:0]      cur_y_reg;
   logic [PAL_AW-1:0]   color_reg;
   logic [4*X_W-1:0]    prim_x_reg;
   logic [4*Y_W-1:0]    prim_y_reg;
   prim_type_e          prim_type_reg;
   logic                pal_we_reg;
   logic [PAL_AW-1:0]   pal_idx_reg;
   logic [23:0]         pal_ycc_reg;
   logic                done_reg, err_reg;

   logic                rd_req, latch_op, exec, restart;
   logic [3:0]          fa_cnt;
   logic [3*X_W-1:0]    fa_x;
   logic [3*Y_W-1:0]    fa_y;
   logic [PAL_AW-1:0]   fa_idx;
   logic [23:0]         fa_ycc;

   vec_arg_fetch #(.X_W(X_W), .Y_W(Y_W), .PAL_AW(PAL_AW)) u_arg_fetch (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (latch_op),
      .byte_valid (rd_valid_reg && (state_reg == ST_FETCH_ARG)),
      .byte_data  (prog_data),
      .rcv_cnt    (fa_cnt),
      .pt_x       (fa_x),
      .pt_y       (fa_y),
      .idx        (fa_idx),
      .ycc        (fa_ycc)
   );

   always_comb begin
      state_next = state_reg;
      rd_req     = 1'b0;
      latch_op   = 1'b0;
      exec       = 1'b0;
      restart    = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_next = ST_FETCH_OP;
               restart    = 1'b1;
            end
         end
         ST_FETCH_OP: begin
            // First cycle issues the read, second cycle decodes the returned opcode.
            if (rd_valid_reg) begin
               latch_op = 1'b1;
               if (!op_valid(prog_data))              state_next = ST_ERROR;
               else if (arg_count(prog_data) == 4'd0) state_next = ST_DONE;
               else                                   state_next = ST_FETCH_ARG;
            end else if (pc_reg == PC_LAST) begin
               state_next = ST_ERROR;
            end else begin
               rd_req = 1'b1;
            end
         end
         ST_FETCH_ARG: begin
            if (fa_cnt == arg_cnt_reg) begin
               exec = 1'b1;
               if (op_reg == OP_LINE || op_reg == OP_QUAD || op_reg == OP_CUBIC)
                  state_next = ST_ISSUE;
               else
                  state_next = ST_FETCH_OP;
            end else if (iss_cnt_reg != arg_cnt_reg) begin
               if (pc_reg == PC_LAST) state_next = ST_ERROR;
               else                   rd_req = 1'b1;
            end
         end
         ST_ISSUE:     if (prim_ready) state_next = ST_WAIT_DRAW;
         ST_WAIT_DRAW: if (draw_done)  state_next = ST_FETCH_OP;
         default:      state_next = ST_IDLE;
      endcase
      if (abort) begin
         state_next = ST_IDLE;
         rd_req     = 1'b0;
         latch_op   = 1'b0;
         exec       = 1'b0;
         restart    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         pc_reg        <= '0;
         op_reg        <= 8'h00;
         arg_cnt_reg   <= 4'd0;
         iss_cnt_reg   <= 4'd0;
         rd_valid_reg  <= 1'b0;
         cur_x_reg     <= '0;
         cur_y_reg     <= '0;
         color_reg     <= '0;
         prim_x_reg    <= '0;
         prim_y_reg    <= '0;
         prim_type_reg <= PT_LINE;
         pal_we_reg    <= 1'b0;
         pal_idx_reg   <= '0;
         pal_ycc_reg   <= 24'h0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rd_valid_reg <= rd_req;
         pal_we_reg   <= 1'b0;
         if (restart) begin
            pc_reg   <= '0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
         end
         if (rd_req) begin
            pc_reg <= pc_reg + 1'b1;
            if (state_reg == ST_FETCH_ARG) iss_cnt_reg <= iss_cnt_reg + 4'd1;
         end
         if (latch_op) begin
            op_reg      <= prog_data;
            arg_cnt_reg <= arg_count(prog_data);
            iss_cnt_reg <= 4'd0;
         end
         if (state_next == ST_DONE)  done_reg <= 1'b1;
         if (state_next == ST_ERROR) err_reg  <= 1'b1;
         if (exec) begin
            // Point 0 of every primitive is the current pen position.
            case (op_reg)
               OP_SET_PAL: begin
                  pal_we_reg  <= 1'b1;
                  pal_idx_reg <= fa_idx;
                  pal_ycc_reg <= fa_ycc;
               end
               OP_MOVE: begin
                  cur_x_reg <= fa_x[X_W-1:0];
                  cur_y_reg <= fa_y[Y_W-1:0];
               end
               OP_SET_COLOR: color_reg <= fa_idx;
               OP_LINE: begin
                  prim_type_reg <= PT_LINE;
                  prim_x_reg    <= {{(2*X_W){1'b0}}, fa_x[X_W-1:0], cur_x_reg};
                  prim_y_reg    <= {{(2*Y_W){1'b0}}, fa_y[Y_W-1:0], cur_y_reg};
               end
               OP_QUAD: begin
                  prim_type_reg <= PT_QUAD;
                  prim_x_reg    <= {{X_W{1'b0}}, fa_x[2*X_W-1:0], cur_x_reg};
                  prim_y_reg    <= {{Y_W{1'b0}}, fa_y[2*Y_W-1:0], cur_y_reg};
               end
               OP_CUBIC: begin
                  prim_type_reg <= PT_CUBIC;
                  prim_x_reg    <= {fa_x, cur_x_reg};
                  prim_y_reg    <= {fa_y, cur_y_reg};
               end
               default: ;
            endcase
         end
         if (state_reg == ST_WAIT_DRAW && draw_done && !abort) begin
            case (prim_type_reg)
               PT_LINE: begin
                  cur_x_reg <= prim_x_reg[X_W +: X_W];
                  cur_y_reg <= prim_y_reg[Y_W +: Y_W];
               end
               PT_QUAD: begin
                  cur_x_reg <= prim_x_reg[2*X_W +: X_W];
                  cur_y_reg <= prim_y_reg[2*Y_W +: Y_W];
               end
               default: begin
                  cur_x_reg <= prim_x_reg[3*X_W +: X_W];
                  cur_y_reg <= prim_y_reg[3*Y_W +: Y_W];
               end
            endcase
         end
      end
   end

   assign busy       = (state_reg == ST_FETCH_OP) || (state_reg == ST_FETCH_ARG) ||
                       (state_reg == ST_ISSUE)    || (state_reg == ST_WAIT_DRAW);
   assign done       = done_reg;
   assign err        = err_reg;
   assign prog_addr  = pc_reg;
   assign prog_rd    = rd_req;
   assign prim_valid = (state_reg == ST_ISSUE);
   assign prim_type  = prim_type_reg;
   assign prim_x     = prim_x_reg;
   assign prim_y     = prim_y_reg;
   assign color_o    = color_reg;
   assign pal_we     = pal_we_reg;
   assign pal_idx    = pal_idx_reg;
   assign pal_ycc    = pal_ycc_reg;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: program memory model plus hand-computed
// expectations for primitives, palette writes, errors, abort and reset.
module tb_vector_sequencer;

   localparam int X_W = 10, Y_W = 9, PROG_AW = 10, PAL_AW = 4;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                start = 1'b0, abort = 1'b0;
   logic                busy, done, err;
   logic [PROG_AW-1:0]  prog_addr;
   logic                prog_rd;
   logic [7:0]          prog_data = 8'h00;
   logic                prim_valid;
   logic                prim_ready = 1'b0;
   logic [1:0]          prim_type;
   logic [4*X_W-1:0]    prim_x;
   logic [4*Y_W-1:0]    prim_y;
   logic [PAL_AW-1:0]   color_o;
   logic                draw_done = 1'b0;
   logic                pal_we;
   logic [PAL_AW-1:0]   pal_idx;
   logic [23:0]         pal_ycc;

   vector_sequencer #(.X_W(X_W), .Y_W(Y_W), .PROG_AW(PROG_AW), .PAL_AW(PAL_AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .err(err),
      .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_data(prog_data),
      .prim_valid(prim_valid), .prim_ready(prim_ready), .prim_type(prim_type),
      .prim_x(prim_x), .prim_y(prim_y), .color_o(color_o), .draw_done(draw_done),
      .pal_we(pal_we), .pal_idx(pal_idx), .pal_ycc(pal_ycc)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [1024];
   logic [7:0] prog [$];
   always @(posedge clk) if (prog_rd) prog_data <= mem[prog_addr];

   int n_vec = 0, n_bad = 0;
   int hs_cnt = 0, pal_cnt = 0, rd_cnt = 0;
   logic [PAL_AW-1:0] pal_idx_cap;
   logic [23:0]       pal_ycc_cap;

   // Event monitor samples mid-low-phase, after the bench has driven inputs.
   always @(negedge clk) begin
      #1;
      if (prim_valid && prim_ready && !abort) hs_cnt++;
      if (pal_we) begin
         pal_cnt++;
         pal_idx_cap = pal_idx;
         pal_ycc_cap = pal_ycc;
      end
      if (prog_rd) rd_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
      for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
   endtask

   task automatic run_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!prim_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!prim_valid) check({tag, " valid timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!(done || err) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!(done || err)) check({tag, " end timeout"}, 64'd0, 64'd1);
   endtask

   task automatic handshake();
      prim_ready = 1'b1;
      @(negedge clk) prim_ready = 1'b0;
   endtask

   task automatic pulse_draw();
      draw_done = 1'b1;
      @(negedge clk) draw_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      logic [4*X_W-1:0] exp_x;
      logic [4*Y_W-1:0] exp_y;

      // Reset overrides a simultaneous start.
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst err", err, 0);
      check("rst prog_rd", prog_rd, 0);
      check("rst prim_valid", prim_valid, 0);
      check("rst pal_we", pal_we, 0);
      check("rst prim_x", prim_x, 0);
      check("rst color", color_o, 0);
      start = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);

      // Single line from pen (10,20) to (100,50).
      prog = {8'h11, 8'h00, 8'h0A, 8'h00, 8'h14, 8'h13, 8'h00, 8'h64, 8'h00, 8'h32, 8'h19};
      load_prog();
      hs_cnt = 0;
      run_start();
      check("line busy", busy, 1);
      wait_valid("line");
      check("line type", prim_type, 0);
      check("line x0", prim_x[0 +: X_W], 10);
      check("line x1", prim_x[X_W +: X_W], 100);
      check("line y0", prim_y[0 +: Y_W], 20);
      check("line y1", prim_y[Y_W +: Y_W], 50);
      check("line unused x", prim_x[2*X_W +: 2*X_W], 0);
      handshake();
      check("line wait valid", prim_valid, 0);
      repeat (3) @(negedge clk);
      check("line pre-draw done", done, 0);
      pulse_draw();
      wait_end("line");
      check("line done", done, 1);
      check("line idle busy", busy, 0);
      check("line hs count", hs_cnt, 1);

      // Palette write and color select.
      prog = {8'h10, 8'h03, 8'h80, 8'h40, 8'hC0, 8'h18, 8'h03, 8'h19};
      load_prog();
      pal_cnt = 0;
      run_start();
      check("pal done cleared", done, 0);
      wait_end("pal");
      check("pal we count", pal_cnt, 1);
      check("pal idx", pal_idx_cap, 3);
      check("pal ycc", pal_ycc_cap, 24'h8040C0);
      check("pal color", color_o, 3);
      check("pal done", done, 1);

      // Cubic with a long stall, then a line proving the pen moved to point 3.
      prog = {8'h11, 8'h00, 8'h05, 8'h00, 8'h06,
              8'h15, 8'h00, 8'h64, 8'h00, 8'hC8, 8'h01, 8'h2C, 8'h00, 8'h96,
                     8'h02, 8'h7F, 8'h01, 8'h8F,
              8'h13, 8'h00, 8'h01, 8'h00, 8'h02, 8'h19};
      load_prog();
      hs_cnt = 0;
      run_start();
      wait_valid("cubic");
      exp_x = {10'd639, 10'd300, 10'd100, 10'd5};
      exp_y = {9'd399, 9'd150, 9'd200, 9'd6};
      check("cubic type", prim_type, 2);
      check("cubic x", prim_x, exp_x);
      check("cubic y", prim_y, exp_y);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         draw_done = (c == 5);
         start     = (c == 10);
         if (!prim_valid || prim_x !== exp_x || prim_y !== exp_y || prim_type !== 2'd2) bad++;
      end
      draw_done = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("cubic stall stable", bad, 0);
      check("cubic hs before ready", hs_cnt, 0);
      handshake();
      check("cubic hs count", hs_cnt, 1);
      pulse_draw();
      wait_valid("cubic follow");
      check("follow x0", prim_x[0 +: X_W], 639);
      check("follow y0", prim_y[0 +: Y_W], 399);
      check("follow x1", prim_x[X_W +: X_W], 1);
      check("follow y1", prim_y[Y_W +: Y_W], 2);
      handshake();
      pulse_draw();
      wait_end("cubic");
      check("cubic done", done, 1);

      // Undefined opcode, then a clean restart.
      prog = {8'h42};
      load_prog();
      run_start();
      wait_end("badop");
      check("badop err", err, 1);
      check("badop busy", busy, 0);
      check("badop done", done, 0);
      rd_cnt = 0;
      repeat (5) @(negedge clk);
      check("badop no reads", rd_cnt, 0);
      prog = {8'h19};
      load_prog();
      run_start();
      check("restart err cleared", err, 0);
      check("restart busy", busy, 1);
      wait_end("restart");
      check("restart done", done, 1);
      check("restart err", err, 0);

      // Abort while waiting for the draw; a late draw_done must not move the pen.
      prog = {8'h11, 8'h00, 8'h0A, 8'h00, 8'h14, 8'h13, 8'h00, 8'h64, 8'h00, 8'h32, 8'h19};
      load_prog();
      run_start();
      wait_valid("abort");
      handshake();
      repeat (2) @(negedge clk);
      check("abort wait busy", busy, 1);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("abort busy", busy, 0);
      check("abort valid", prim_valid, 0);
      rd_cnt = 0;
      pulse_draw();
      repeat (3) @(negedge clk);
      check("abort stays idle", busy, 0);
      check("abort no reads", rd_cnt, 0);
      check("abort no done", done, 0);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort beats start", busy, 0);
      prog = {8'h13, 8'h00, 8'h07, 8'h00, 8'h08, 8'h19};
      load_prog();
      run_start();
      wait_valid("post abort");
      check("post abort x0", prim_x[0 +: X_W], 10);
      check("post abort y0", prim_y[0 +: Y_W], 20);
      check("post abort x1", prim_x[X_W +: X_W], 7);
      handshake();
      pulse_draw();
      wait_end("post abort");

      // Out-of-range MOVE: clamped or truncated depending on build.
      prog = {8'h11, 8'h03, 8'hFF, 8'h01, 8'hFF, 8'h13, 8'h00, 8'h01, 8'h00, 8'h01, 8'h19};
      load_prog();
      run_start();
      wait_valid("clip");
`ifdef VEC_SEQ_CLIP_EN
      check("clip x0", prim_x[0 +: X_W], 639);
      check("clip y0", prim_y[0 +: Y_W], 399);
`else
      check("clip x0", prim_x[0 +: X_W], 1023);
      check("clip y0", prim_y[0 +: Y_W], 511);
`endif

      // Reset in the middle of an issued primitive.
      start = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst valid", prim_valid, 0);
      check("midrst busy", busy, 0);
      check("midrst prim_x", prim_x, 0);
      check("midrst color", color_o, 0);
      check("midrst done", done, 0);
      start = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter X_W, default 10, meaning X coordinate width.
REQ-002 SHALL have parameter Y_W, default 9, meaning Y coordinate width.
REQ-003 SHALL have parameter PROG_AW, default 10, meaning program memory byte-address width.
REQ-004 SHALL have parameter PAL_AW, default 4, meaning palette index width; color_o width is PAL_AW.
REQ-005 SHALL have one clock; reset is synchronous and active-low; ports: clk  in  1  clock; reset_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  begin program at byte 0 | abort  in  1  return to IDLE | busy  out  1 | done  out  1  sticky until start | err  out  1  sticky until start.
REQ-007 SHALL have program port: prog_addr  out  PROG_AW | prog_rd  out  1 | prog_data  in  8, valid exactly one cycle after prog_rd.
REQ-008 SHALL have primitive port: prim_valid  out  1 | prim_ready  in  1 | prim_type  out  2 (0 line, 1 quad, 2 cubic) | prim_x  out  4*X_W, point k at [k*X_W +: X_W] | prim_y  out  4*Y_W, same packing | color_o  out  PAL_AW | draw_done  in  1, one-cycle pulse.
REQ-009 SHALL have palette port: pal_we  out  1 | pal_idx  out  PAL_AW | pal_ycc  out  24 ({Y,Cr,Cb}).

Function
REQ-010 Opcodes SHALL be: 0x10 SET_PAL (idx,Y,Cr,Cb); 0x11 MOVE (x,y); 0x13 LINE (x,y); 0x14 QUAD (2 points); 0x15 CUBIC (3 points); 0x18 SET_COLOR (idx); 0x19 SHOW (none).
REQ-011 Each coordinate SHALL be two bytes, big-endian, truncated to X_W/Y_W LSBs; each index one byte truncated to PAL_AW LSBs.
REQ-012 States SHALL be IDLE, FETCH_OP, FETCH_ARG, ISSUE, WAIT_DRAW, DONE, ERROR.
REQ-013 IDLE->FETCH_OP on start; pc cleared to 0, done and err cleared.
REQ-014 FETCH_OP SHALL assert prog_rd, latch opcode next cycle, load argument byte count, go to FETCH_ARG (count>0), else execute.
REQ-015 FETCH_ARG SHALL issue one read per cycle (pipelined), pc incrementing per byte; throughput 1 byte/cycle.
REQ-016 MOVE SHALL update pen (cur_x, cur_y) only; SET_COLOR SHALL update color_o; SET_PAL SHALL pulse pal_we one cycle with pal_idx/pal_ycc.
REQ-017 LINE/QUAD/CUBIC SHALL enter ISSUE with point 0 = pen, following points from arguments, unused points zero.
REQ-018 ISSUE SHALL hold prim_valid and all prim_* stable until prim_valid&prim_ready, then go to WAIT_DRAW.
REQ-019 WAIT_DRAW SHALL, on draw_done, set pen to final point and go to FETCH_OP; draw_done outside WAIT_DRAW SHALL be ignored.
REQ-020 SHOW SHALL go to DONE: done=1, busy=0; stays until start.
REQ-021 Undefined opcode SHALL go to ERROR: err=1, busy=0, no further reads.
REQ-022 pc reaching 2^PROG_AW-1 with bytes still required SHALL go to ERROR (no wrap).
REQ-023 abort SHALL return to IDLE next cycle from any state, dropping prim_valid; abort wins over simultaneous start.
REQ-024 start while busy SHALL be ignored.
REQ-025 busy SHALL be 1 in FETCH_OP, FETCH_ARG, ISSUE, WAIT_DRAW.

Reset
REQ-026 reset_n=0 SHALL force IDLE; busy, done, err, prog_rd, prim_valid, pal_we = 0; pc, pen, color_o, prim_x, prim_y = 0, overriding all inputs.

Configuration
REQ-027 With VEC_SEQ_CLIP_EN defined, each decoded coordinate SHALL be clamped to X_MAX=639 / Y_MAX=399 (package constants) before truncation; without it, truncation only.

Structure
REQ-028 Package vec_seq_pkg SHALL hold opcode constants, state enum, prim_type enum, argument-count table, X_MAX/Y_MAX.
REQ-029 Sub-module vec_arg_fetch SHALL assemble argument bytes into coordinate/index fields.

Verification
REQ-030 Program {11 00 0A 00 14, 13 00 64 00 32, 19}: one line prim, prim_x points 0/1 = 10/100, prim_y = 20/50; done=1 after draw_done.
REQ-031 Cubic 15 + 6 coords with prim_ready held low 20 cycles: prim_* stable, single handshake, pen = point 3 after draw_done.
REQ-032 {10 03 80 40 C0, 18 03, 19}: pal_we one cycle, pal_idx=3, pal_ycc=0x8040C0; color_o=3.
REQ-033 Opcode 0x42 at byte 0: err=1, busy=0, prog_rd=0 thereafter; start restarts cleanly.
REQ-034 abort during WAIT_DRAW: IDLE next cycle, prim_valid=0, later draw_done ignored.
REQ-035 MOVE to x=0x03FF with VEC_SEQ_CLIP_EN: pen x=639; without: pen x=1023.
